// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX operand register with same-cycle writeback bypass, MEM/WB forwarding
// into the EX operands, and load-use hazard detection. EX and MEM destination
// metadata are tracked here so writeback does not have to return them.
module id_ex_operand_stage #(
  parameter int         DATA_W = 64,
  parameter logic [4:0] XZR    = 5'd31
) (
  input  logic              clk,
  input  logic              reset_n,
  // Decode-side instruction
  input  logic              id_valid,
  input  logic [4:0]        id_ra1,
  input  logic [4:0]        id_ra2,
  input  logic [4:0]        id_wa,
  input  logic              id_regwrite,
  input  logic              id_memread,
  // Register file read data
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  // Squash of the instruction entering EX
  input  logic              flush,
  // MEM-stage result
  input  logic [DATA_W-1:0] mem_alu_result,
  // Writeback port (shared with the register file)
  input  logic              wb_we3,
  input  logic [4:0]        wb_wa3,
  input  logic [DATA_W-1:0] wb_wd3,
  // Hazard and EX-stage outputs
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [4:0]        ex_wa,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb
);

  // A producer matches a source when it is live, writes, targets that source
  // and the source is not the hard-wired zero register.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] wa,
                                     input logic       we,
                                     input logic       v);
    return v && we && (wa == r) && (r != XZR);
  endfunction

  // ID/EX state
  logic              ex_valid_q,    ex_valid_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic              ex_memread_q,  ex_memread_d;
  logic [4:0]        ex_wa_q,       ex_wa_d;
  logic [4:0]        ra1_q,         ra1_d;
  logic [4:0]        ra2_q,         ra2_d;
  logic [DATA_W-1:0] rd1_q,         rd1_d;
  logic [DATA_W-1:0] rd2_q,         rd2_d;

  // EX/MEM metadata
  logic              mem_valid_q;
  logic              mem_regwrite_q;
  logic              mem_memread_q;
  logic [4:0]        mem_wa_q;

  logic              load_hit;
  logic              bubble;
  logic              mem_fwd_a, mem_fwd_b;
  logic              wb_fwd_a,  wb_fwd_b;

  // Load-use detection: a load in EX whose destination a decode source needs.
  // A flush squashes the consumer anyway, so it masks the stall.
  always_comb begin
    load_hit = reg_match(id_ra1, ex_wa_q, ex_regwrite_q, 1'b1) ||
               reg_match(id_ra2, ex_wa_q, ex_regwrite_q, 1'b1);
    stall    = !flush && id_valid && ex_valid_q && ex_memread_q && load_hit;
    bubble   = flush || stall;
  end

  // ID/EX next state: bubble on flush/stall, writeback bypass on operand capture
  // because the register file read in this cycle does not yet see the write.
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    if (!bubble) begin
      ex_valid_d    = id_valid;
      ex_regwrite_d = id_regwrite;
      ex_memread_d  = id_memread;
    end
    ex_wa_d = id_wa;
    ra1_d   = id_ra1;
    ra2_d   = id_ra2;
    rd1_d   = reg_match(id_ra1, wb_wa3, wb_we3, 1'b1) ? wb_wd3 : rd1;
    rd2_d   = reg_match(id_ra2, wb_wa3, wb_we3, 1'b1) ? wb_wd3 : rd2;
  end

  // ID/EX register. Source indices reset to XZR so nothing forwards while the
  // stage is empty and the operands read back as the cleared captured data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_wa_q       <= 5'd0;
      ra1_q         <= XZR;
      ra2_q         <= XZR;
      rd1_q         <= '0;
      rd2_q         <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_wa_q       <= ex_wa_d;
      ra1_q         <= ra1_d;
      ra2_q         <= ra2_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
    end
  end

  // EX/MEM metadata follows the EX stage unconditionally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_wa_q       <= 5'd0;
    end else begin
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memread_q  <= ex_memread_q;
      mem_wa_q       <= ex_wa_q;
    end
  end

  // Operand forwarding: MEM (younger) over WB over the captured value. A load
  // in MEM has no data yet, so it never forwards from mem_alu_result.
  always_comb begin
    mem_fwd_a = reg_match(ra1_q, mem_wa_q, mem_regwrite_q, mem_valid_q) && !mem_memread_q;
    mem_fwd_b = reg_match(ra2_q, mem_wa_q, mem_regwrite_q, mem_valid_q) && !mem_memread_q;
    wb_fwd_a  = reg_match(ra1_q, wb_wa3, wb_we3, 1'b1);
    wb_fwd_b  = reg_match(ra2_q, wb_wa3, wb_we3, 1'b1);

    if (mem_fwd_a)     ex_opa = mem_alu_result;
    else if (wb_fwd_a) ex_opa = wb_wd3;
    else               ex_opa = rd1_q;

    if (mem_fwd_b)     ex_opb = mem_alu_result;
    else if (wb_fwd_b) ex_opb = wb_wd3;
    else               ex_opb = rd2_q;
  end

  assign ex_valid    = ex_valid_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;
  assign ex_wa       = ex_wa_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture, writeback bypass,
// forwarding priority, load-use stall, XZR handling, flush and reset.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_ra1, id_ra2, id_wa;
  logic        id_regwrite, id_memread;
  logic [63:0] rd1, rd2;
  logic        flush;
  logic [63:0] mem_alu_result;
  logic        wb_we3;
  logic [4:0]  wb_wa3;
  logic [63:0] wb_wd3;
  logic        stall, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_wa;
  logic [63:0] ex_opa, ex_opb;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_operand_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_ra1         (id_ra1),
    .id_ra2         (id_ra2),
    .id_wa          (id_wa),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .rd1            (rd1),
    .rd2            (rd2),
    .flush          (flush),
    .mem_alu_result (mem_alu_result),
    .wb_we3         (wb_we3),
    .wb_wa3         (wb_wa3),
    .wb_wd3         (wb_wd3),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_wa          (ex_wa),
    .ex_opa         (ex_opa),
    .ex_opb         (ex_opb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] ra1, input logic [63:0] d1,
                         input logic [4:0] ra2, input logic [63:0] d2,
                         input logic [4:0] wa, input logic rw, input logic mr);
    id_valid    = v;
    id_ra1      = ra1;
    rd1         = d1;
    id_ra2      = ra2;
    rd2         = d2;
    id_wa       = wa;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] wa, input logic [63:0] wd);
    wb_we3 = we;
    wb_wa3 = wa;
    wb_wd3 = wd;
  endtask

  initial begin
    reset_n        = 1'b0;
    flush          = 1'b0;
    mem_alu_result = 64'h0;
    set_wb(1'b1, 5'd0, 64'hBAD0);
    set_dec(1'b1, 5'd0, 64'h55, 5'd0, 64'h66, 5'd1, 1'b1, 1'b1);

    // Reset held across edges: nothing captured
    tick(); tick();
    chk("rst_stall",    64'(stall),    64'h0);
    chk("rst_ex_valid", 64'(ex_valid), 64'h0);
    chk("rst_opa",      ex_opa,        64'h0);
    chk("rst_opb",      ex_opb,        64'h0);

    reset_n = 1'b1;
    set_wb(1'b0, 5'd0, 64'h0);

    // Basic capture
    set_dec(1'b1, 5'd3, 64'h33, 5'd4, 64'h44, 5'd10, 1'b1, 1'b0);
    #1 chk("cap_stall", 64'(stall), 64'h0);
    tick();
    chk("cap_opa",      ex_opa,          64'h33);
    chk("cap_opb",      ex_opb,          64'h44);
    chk("cap_ex_valid", 64'(ex_valid),   64'h1);
    chk("cap_ex_wa",    64'(ex_wa),      64'd10);
    chk("cap_ex_rw",    64'(ex_regwrite),64'h1);

    // Writeback write-through at decode
    set_dec(1'b1, 5'd6, 64'h66, 5'd5, 64'h0, 5'd11, 1'b1, 1'b0);
    set_wb(1'b1, 5'd5, 64'hAA);
    tick();
    set_wb(1'b0, 5'd0, 64'h0);
    #1;
    chk("wbt_opb", ex_opb, 64'hAA);
    chk("wbt_opa", ex_opa, 64'h66);

    // MEM over WB priority: producer writes X7, consumer reads X7
    set_dec(1'b1, 5'd1, 64'h1, 5'd2, 64'h2, 5'd7, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 5'd7, 64'h77, 5'd8, 64'h88, 5'd12, 1'b1, 1'b0);
    tick();
    mem_alu_result = 64'h70;
    set_wb(1'b1, 5'd7, 64'h11);
    #1;
    chk("prio_opa", ex_opa, 64'h70);
    chk("prio_opb", ex_opb, 64'h88);
    set_wb(1'b0, 5'd0, 64'h0);

    // Load-use on X9 via source 1
    set_dec(1'b1, 5'd1, 64'h1, 5'd2, 64'h2, 5'd9, 1'b1, 1'b1);
    tick();
    chk("lu_ex_memread", 64'(ex_memread), 64'h1);
    set_dec(1'b1, 5'd9, 64'hDEAD, 5'd2, 64'h22, 5'd13, 1'b1, 1'b0);
    #1 chk("lu_stall", 64'(stall), 64'h1);
    tick();
    chk("lu_bubble_valid", 64'(ex_valid), 64'h0);
    chk("lu_stall_drop",   64'(stall),    64'h0);
    tick();
    set_wb(1'b1, 5'd9, 64'h99);
    #1;
    chk("lu_opa_wb",   ex_opa,        64'h99);
    chk("lu_opb",      ex_opb,        64'h22);
    chk("lu_ex_valid", 64'(ex_valid), 64'h1);
    set_wb(1'b0, 5'd0, 64'h0);

    // Load-use via source 2
    set_dec(1'b1, 5'd1, 64'h1, 5'd2, 64'h2, 5'd14, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd3, 64'h3, 5'd14, 64'h0, 5'd15, 1'b1, 1'b0);
    #1 chk("lu2_stall", 64'(stall), 64'h1);
    tick();
    chk("lu2_stall_drop", 64'(stall), 64'h0);

    // XZR: load to X31 in EX, decode reads X31 and writes X31
    set_dec(1'b1, 5'd1, 64'h1, 5'd2, 64'h2, 5'd31, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd31, 64'h0, 5'd31, 64'h0, 5'd31, 1'b1, 1'b0);
    #1 chk("xzr_stall", 64'(stall), 64'h0);
    tick();
    set_wb(1'b1, 5'd31, 64'hFF);
    #1 chk("xzr_opa_wb", ex_opa, 64'h0);
    set_dec(1'b1, 5'd31, 64'h0, 5'd4, 64'h4, 5'd16, 1'b1, 1'b0);
    tick();
    mem_alu_result = 64'h3131;
    #1;
    chk("xzr_opa_mem", ex_opa, 64'h0);
    chk("xzr_opb",     ex_opb, 64'h4);
    set_wb(1'b0, 5'd0, 64'h0);

    // Flush during a load-use stall
    set_dec(1'b1, 5'd1, 64'h1, 5'd2, 64'h2, 5'd4, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd4, 64'h0, 5'd2, 64'h2, 5'd17, 1'b1, 1'b0);
    #1 chk("fl_stall_pre", 64'(stall), 64'h1);
    flush = 1'b1;
    #1 chk("fl_stall", 64'(stall), 64'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_ex_valid", 64'(ex_valid),    64'h0);
    chk("fl_ex_rw",    64'(ex_regwrite), 64'h0);
    chk("fl_stall_after", 64'(stall),    64'h0);

    // Reset asserted in the middle of a stall
    set_dec(1'b1, 5'd1, 64'h5, 5'd2, 64'h6, 5'd6, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd6, 64'h0, 5'd2, 64'h2, 5'd18, 1'b1, 1'b0);
    #1 chk("rs_stall_pre", 64'(stall), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("rs_stall",    64'(stall),       64'h0);
    chk("rs_ex_valid", 64'(ex_valid),    64'h0);
    chk("rs_ex_mr",    64'(ex_memread),  64'h0);
    chk("rs_ex_rw",    64'(ex_regwrite), 64'h0);
    chk("rs_ex_wa",    64'(ex_wa),       64'h0);
    chk("rs_opa",      ex_opa,           64'h0);
    chk("rs_opb",      ex_opb,           64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Operand-fetch and hazard block between decode and execute in the 64-bit ARM pipeline. It captures `rd1`/`rd2` from `regfile` into the ID/EX register, and bypasses same-cycle writeback because `regfile` writes on the clock edge and a same-cycle read is stale. It supplies forwarded EX operands from MEM/WB and detects load-use hazards, stalling decode for one cycle and inserting a bubble. It also tracks EX and MEM destination metadata internally so the writeback stage need not return it.

## Interface
- `XZR`, 31: zero-register index; never matches for forwarding or hazards.
- `clk` in 1: clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_ra1`, `id_ra2` in 5: source registers, also driven to `regfile` `ra1`/`ra2`.
- `id_wa` in 5: destination register of the decode instruction.
- `id_regwrite` in 1: decode instruction writes `id_wa`.
- `id_memread` in 1: decode instruction is a load.
- `rd1`, `rd2` in 64: `regfile` read data.
- `flush` in 1: squash the instruction entering EX (taken branch).
- `mem_alu_result` in 64: result of the instruction currently in MEM.
- `wb_we3`, `wb_wa3`, `wb_wd3` in 1/5/64: writeback port, also driven to `regfile`.
- `stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid`, `ex_regwrite`, `ex_memread` out 1: EX-stage control.
- `ex_wa` out 5: EX-stage destination register.
- `ex_opa`, `ex_opb` out 64: forwarded EX operands.

## Operation
- **Reset (`reset_n`=0, asynchronous):** all EX and MEM registers clear to 0: valid, regwrite, memread, wa, captured rd1/rd2.
  - Consequence: `stall`=0, `ex_valid`=0, `ex_opa`=`ex_opb`=0 while reset is held.
  - Reset mid-stall drops the bubble and the pending instruction.
- **match(r, wa, we, v):** v && we && wa==r && r!=XZR.
- **Load-use hazard:** `stall` = id_valid && ex_valid && ex_memread && (match(id_ra1, ex_wa, ex_regwrite, 1) || match(id_ra2, ex_wa, ex_regwrite, 1)).
  - Combinational.
  - Not asserted while `flush`=1.
- **ID/EX capture on posedge:**
  - If `flush` or `stall`: `ex_valid`←0, `ex_regwrite`←0, `ex_memread`←0. This is the bubble; operand registers are don't-care.
  - Else: `ex_valid`←id_valid, and the control/wa fields are copied from decode.
  - Operand capture: rd1_q ← match(id_ra1, wb_wa3, wb_we3, 1) ? wb_wd3 : rd1. rd2_q is the same with ra2.
  - ra1_q/ra2_q latch `id_ra1`/`id_ra2`.
- **EX/MEM metadata on posedge:** mem_valid/mem_wa/mem_regwrite/mem_memread ← EX values, unconditionally.
- **Forwarding (combinational, priority MEM > WB > captured):**
  - `ex_opa` = (match(ra1_q, mem_wa, mem_regwrite, mem_valid) && !mem_memread) ? mem_alu_result : match(ra1_q, wb_wa3, wb_we3, 1) ? wb_wd3 : rd1_q.
  - `ex_opb` is the same with ra2_q/rd2_q.
- **XZR:** a source of XZR always yields the captured `regfile` value, which is 0.
- **Widths:** all data paths are 64-bit with no arithmetic; comparisons are 5-bit equality.

## Timing
- Capture latency: 1 cycle from decode to EX outputs.
- Forwarding: zero-cycle combinational paths from `mem_alu_result` and `wb_wd3` to `ex_opa`/`ex_opb`.
- **Stall:** exactly one cycle per load-use pair.
  - The next cycle the load is in MEM, so `ex_memread` of a bubble is 0 and `stall` drops.
  - The consumer enters EX one cycle later and takes the load data via the WB path.
- **Flush and stall same cycle:** flush wins and `stall`=0; the bubble is inserted either way.
- **Back-to-back loads to the same register:** each consumer stalls independently.
- **Same register matches MEM and WB:** MEM wins (younger value).

## Test plan
- **Reset and capture:** release `reset_n`, then id_ra1=3, rd1=64'h33, id_valid=1 → next cycle `ex_opa`=64'h33, `ex_valid`=1, `stall`=0 throughout.
- **WB write-through at decode:** id_ra2=5, rd2=0, wb_we3=1, wb_wa3=5, wb_wd3=64'hAA in the same cycle → `ex_opb`=64'hAA after capture.
- **MEM-over-WB priority:**
  - Setup: EX instruction writes X7, followed by a consumer reading X7.
  - Stimulus: in the consumer's EX cycle, mem_alu_result=64'h70 and WB also writes X7=64'h11.
  - Required: `ex_opa`=64'h70.
- **Load-use:**
  - Setup: a load to X9 is in EX (ex_memread=1).
  - Stimulus: decode id_ra1=9.
  - Required: `stall`=1 for one cycle and a bubble in EX (`ex_valid`=0). Then the consumer captures and `ex_opa`=wb_wd3 (64'h99) when WB writes X9.
- **XZR:** an EX instruction writes X31 and a load in EX targets X31, with decode id_ra1=31 → `stall`=0, no forwarding, `ex_opa`=0.
- **Flush and reset during a stall:**
  - Asserting `flush` during a load-use stall → `stall`=0 and `ex_valid`=0 next cycle.
  - Asserting `reset_n`=0 mid-stall → all EX outputs 0 immediately.
